hs_fifo_pkt_ingress: RTL

Packet admission stage placed directly upstream of `hs_fifo_sfifo` when that FIFO runs with `EN_LAST_SIGNAL`, `EN_PACKET_MODE` and `EN_DROP_PACKET` enabled. It accepts a valid/ready word stream with `last` and `err` markers and counts words per packet. It forwards good packets through one output register and replaces errored or oversize packets with a single drop token, which makes the FIFO discard the uncommitted words. Saturating statistics counters report good and dropped packets.

---
 rtl/hs_fifo_pkt_ingress_pkg.sv | 24 ++
 rtl/hs_ifr_misc_typedefs_pkg.sv | 10 +
 rtl/hs_fifo_pkt_ingress_oreg.sv | 73 +++++++
 rtl/hs_fifo_pkt_ingress.sv | 126 ++++++++++++
 4 files changed

// File: rtl/hs_fifo_pkt_ingress_pkg.sv
// Types and helpers shared by the packet ingress stage,
// its output register and any bench that drives it.
package hs_fifo_pkt_ingress_pkg;

    typedef hs_ifr_misc_typedefs_pkg::bool_e bool_e;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DISCARD
    } ingress_state_e;

    typedef enum logic [1:0] {
        DROP_NONE,
        DROP_ERR,
        DROP_OVERSIZE
    } drop_reason_e;

    // Word counter must hold 0..max_len inclusive, so it never wraps.
    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/hs_ifr_misc_typedefs_pkg.sv
// Miscellaneous shared typedefs for the hs_fifo IP family.
// Small enough to be pulled into any package that needs them.
package hs_ifr_misc_typedefs_pkg;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_e;

endpackage

// File: rtl/hs_fifo_pkt_ingress_oreg.sv
// One-entry output register holding either a data word or a
// one-cycle drop token, plus the upstream-side free indication.
module hs_fifo_pkt_ingress_oreg #(
    parameter type DATA_TYPE = logic [15:0]
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     load_word_i,
    input  logic     load_drop_i,
    input  DATA_TYPE data_i,
    input  logic     last_i,
    input  logic     m_ready_i,
    output logic     m_valid_o,
    output logic     m_drop_o,
    output DATA_TYPE m_data_o,
    output logic     m_last_o,
    output logic     free_o
);

    logic     valid_q, valid_d;
    logic     drop_q,  drop_d;
    DATA_TYPE data_q,  data_d;
    logic     last_q,  last_d;

    // Slot can take a new entry if empty or its word retires now;
    // a drop token blocks for its single cycle (the bubble).
    assign free_o = !(valid_q || drop_q) || (valid_q && m_ready_i);

    // Next-state: retire on handshake, drop token self-clears,
    // then a new load overrides.
    always_comb begin
        valid_d = valid_q;
        drop_d  = 1'b0;
        data_d  = data_q;
        last_d  = last_q;
        if (drop_q || (valid_q && m_ready_i)) begin
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
        end
        if (load_word_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (load_drop_i) begin
            valid_d = 1'b0;
            drop_d  = 1'b1;
            data_d  = '0;
            last_d  = 1'b0;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign m_valid_o = valid_q;
    assign m_drop_o  = drop_q;
    assign m_data_o  = data_q;
    assign m_last_o  = last_q;

endmodule

// File: rtl/hs_fifo_pkt_ingress.sv
// Packet admission stage: forwards good packets, replaces errored
// or oversize packets by a drop token, keeps saturating stats.
module hs_fifo_pkt_ingress
    import hs_fifo_pkt_ingress_pkg::*;
#(
    parameter type DATA_TYPE   = logic [15:0],
    parameter int  MAX_PKT_LEN = 64,
    parameter int  STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  DATA_TYPE          s_data,
    input  logic              s_last,
    input  logic              s_err,
    output logic              m_valid,
    input  logic              m_ready,
    output DATA_TYPE          m_data,
    output logic              m_last,
    output logic              m_drop,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] pkt_ok_cnt,
    output logic [STAT_W-1:0] pkt_drop_cnt
);

    localparam int CNT_W = cnt_width(MAX_PKT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_LEN);

    if (MAX_PKT_LEN < 1) begin : g_bad_len
        $error("MAX_PKT_LEN must be at least 1");
    end

    ingress_state_e     state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic [STAT_W-1:0]  ok_q;
    logic [STAT_W-1:0]  drop_q;

    logic oreg_free;
    logic accept;
    logic in_pkt;
    logic oversize;
    logic err_last;
    logic load_word;
    logic load_drop;

    // Discarding never touches the output register, so it never stalls.
    assign s_ready   = !rst && ((state_q == DISCARD) || oreg_free);
    assign accept    = s_valid && s_ready;
    assign in_pkt    = accept && (state_q != DISCARD);
    assign oversize  = (cnt_q == CNT_MAX);
    assign err_last  = s_last && (s_err || err_q);
    assign load_drop = in_pkt && (oversize || err_last);
    assign load_word = in_pkt && !oversize && !err_last;

    hs_fifo_pkt_ingress_oreg #(
        .DATA_TYPE (DATA_TYPE)
    ) u_oreg (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_word_i (load_word),
        .load_drop_i (load_drop),
        .data_i      (s_data),
        .last_i      (s_last),
        .m_ready_i   (m_ready),
        .m_valid_o   (m_valid),
        .m_drop_o    (m_drop),
        .m_data_o    (m_data),
        .m_last_o    (m_last),
        .free_o      (oreg_free)
    );

    // Packet FSM with word counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            unique case (state_q)
                DISCARD: begin
                    if (s_last) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    if (oversize) begin
                        state_q <= s_last ? IDLE : DISCARD;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end else if (s_last) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end else begin
                        state_q <= PASS;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        err_q   <= err_q || s_err;
                    end
                end
            endcase
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            ok_q   <= '0;
            drop_q <= '0;
        end else begin
            if (m_valid && m_ready && m_last && (ok_q != '1)) begin
                ok_q <= ok_q + STAT_W'(1);
            end
            if (m_drop && (drop_q != '1)) begin
                drop_q <= drop_q + STAT_W'(1);
            end
        end
    end

    assign pkt_ok_cnt   = ok_q;
    assign pkt_drop_cnt = drop_q;

endmodule
